// File: rtl/l2_cache_pkg.sv
// Shared types and width helpers for the n-way L2 cache.
package l2_cache_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CHECK,
      WRITEBACK,
      FILL
   } state_e;

   localparam int DEF_OFFSET = 5;
   localparam int DEF_INDEX  = 4;
   localparam int DEF_WAYS   = 4;

   function automatic int line_bytes(input int off);
      return 1 << off;
   endfunction

   function automatic int line_bits(input int off);
      return 8 << off;
   endfunction

   function automatic int plru_bits(input int ways);
      return ways - 1;
   endfunction

endpackage

// File: rtl/l2_cache_if.sv
// Upstream request bus and physical memory bus of the L2 cache.
interface l2_cache_if
   import l2_cache_pkg::*;
#(
   parameter int s_offset = DEF_OFFSET
) ();

   localparam int LB = line_bytes(s_offset);
   localparam int LW = line_bits(s_offset);

   logic [31:0]   mem_address;
   logic          mem_read;
   logic          mem_write;
   logic [LB-1:0] mem_byte_enable;
   logic [LW-1:0] mem_wdata;
   logic [LW-1:0] mem_rdata;
   logic          mem_resp;
   logic [31:0]   pmem_address;
   logic          pmem_read;
   logic          pmem_write;
   logic [LW-1:0] pmem_wdata;
   logic [LW-1:0] pmem_rdata;
   logic          pmem_resp;

   modport slave (
      input  mem_address, mem_read, mem_write,
      input  mem_byte_enable, mem_wdata,
      output mem_rdata, mem_resp,
      output pmem_address, pmem_read, pmem_write,
      output pmem_wdata,
      input  pmem_rdata, pmem_resp
   );

   modport master (
      output mem_address, mem_read, mem_write,
      output mem_byte_enable, mem_wdata,
      input  mem_rdata, mem_resp,
      input  pmem_address, pmem_read, pmem_write,
      input  pmem_wdata,
      output pmem_rdata, pmem_resp
   );

endinterface

// File: rtl/l2_cache_plru.sv
// Per-set tree pseudo-LRU: heap-ordered node bits, 1 points right.
module l2_plru
   import l2_cache_pkg::*;
#(
   parameter int NUM_WAYS = DEF_WAYS,
   parameter int SETS     = 1 << DEF_INDEX
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [$clog2(SETS)-1:0]     idx_i,
   input  logic                        upd_i,
   input  logic [$clog2(NUM_WAYS)-1:0] way_i,
   output logic [$clog2(NUM_WAYS)-1:0] victim_o
);

   localparam int LVL = $clog2(NUM_WAYS);
   localparam int PW  = plru_bits(NUM_WAYS);

   logic [PW:1] bits_q [SETS];
   logic [PW:1] bits_d [SETS];

   always_comb begin
      logic [LVL:0] node;
      node = (LVL+1)'(1);
      for (int l = 0; l < LVL; l++) begin
         node = {node[LVL-1:0], bits_q[idx_i][node[LVL-1:0]]};
      end
      victim_o = node[LVL-1:0];
   end

   // Each node on the accessed path is turned to face away from it.
   always_comb begin
      logic [LVL:0] node;
      logic         dir;
      bits_d = bits_q;
      node   = (LVL+1)'(1);
      dir    = 1'b0;
      if (upd_i) begin
         for (int l = 0; l < LVL; l++) begin
            dir = way_i[LVL-1-l];
            bits_d[idx_i][node[LVL-1:0]] = ~dir;
            node = {node[LVL-1:0], dir};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         bits_q <= '{default: '0};
      end else begin
         bits_q <= bits_d;
      end
   end

endmodule

// File: rtl/l2_cache_nway.sv
// N-way write-back, write-allocate L2 cache with tree PLRU.
// Define L2_PERF_CNT_EN to add the hit_count/miss_count outputs.
module l2_cache_nway
   import l2_cache_pkg::*;
#(
   parameter int s_offset = DEF_OFFSET,
   parameter int s_index  = DEF_INDEX,
   parameter int NUM_WAYS = DEF_WAYS
) (
   input  logic        clk,
   input  logic        rst,
   l2_cache_if.slave   bus
`ifdef L2_PERF_CNT_EN
   ,
   output logic [31:0] hit_count,
   output logic [31:0] miss_count
`endif
);

   localparam int LB    = line_bytes(s_offset);
   localparam int LW    = line_bits(s_offset);
   localparam int TAG_W = 32 - s_offset - s_index;
   localparam int SETS  = 1 << s_index;
   localparam int WAY_W = $clog2(NUM_WAYS);

   typedef logic [LW-1:0]    line_t;
   typedef logic [TAG_W-1:0] tag_t;
   typedef logic [WAY_W-1:0] way_t;

   state_e          state_q, state_d;
   logic [31:0]     addr_q, addr_d;
   line_t           wdata_q, wdata_d;
   logic [LB-1:0]   be_q, be_d;
   logic            wr_q, wr_d;
   way_t            victim_q, victim_d;

   line_t           data_q  [NUM_WAYS][SETS];
   tag_t            tag_q   [NUM_WAYS][SETS];
   logic [SETS-1:0] valid_q [NUM_WAYS];
   logic [SETS-1:0] dirty_q [NUM_WAYS];

   logic [s_index-1:0] idx;
   tag_t               tag;
   logic               hit;
   way_t               hit_way;
   line_t              hit_line;
   line_t              merged;
   logic               inv_found;
   way_t               inv_way;
   way_t               plru_way;
   way_t               victim;
   logic               plru_upd;

   logic  arr_we;
   way_t  arr_way;
   line_t arr_line;
   logic  arr_dirty;

   assign idx = addr_q[s_offset +: s_index];
   assign tag = addr_q[31 -: TAG_W];

   always_comb begin
      hit     = 1'b0;
      hit_way = '0;
      for (int w = 0; w < NUM_WAYS; w++) begin
         if (valid_q[w][idx] && tag_q[w][idx] == tag) begin
            hit     = 1'b1;
            hit_way = way_t'(w);
         end
      end
   end

   // Descending scan leaves the lowest invalid way selected.
   always_comb begin
      inv_found = 1'b0;
      inv_way   = '0;
      for (int w = NUM_WAYS - 1; w >= 0; w--) begin
         if (!valid_q[w][idx]) begin
            inv_found = 1'b1;
            inv_way   = way_t'(w);
         end
      end
   end

   assign victim   = inv_found ? inv_way : plru_way;
   assign hit_line = data_q[hit_way][idx];

   always_comb begin
      merged = hit_line;
      for (int b = 0; b < LB; b++) begin
         if (be_q[b]) merged[b*8 +: 8] = wdata_q[b*8 +: 8];
      end
   end

   always_comb begin
      state_d           = state_q;
      addr_d            = addr_q;
      wdata_d           = wdata_q;
      be_d              = be_q;
      wr_d              = wr_q;
      victim_d          = victim_q;
      bus.mem_resp      = 1'b0;
      bus.mem_rdata     = '0;
      bus.pmem_read     = 1'b0;
      bus.pmem_write    = 1'b0;
      bus.pmem_address  = '0;
      bus.pmem_wdata    = '0;
      arr_we            = 1'b0;
      arr_way           = hit_way;
      arr_line          = merged;
      arr_dirty         = 1'b1;
      plru_upd          = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.mem_read || bus.mem_write) begin
               addr_d  = bus.mem_address;
               wdata_d = bus.mem_wdata;
               be_d    = bus.mem_byte_enable;
               wr_d    = bus.mem_write;
               state_d = CHECK;
            end
         end
         CHECK: begin
            if (hit) begin
               bus.mem_resp = 1'b1;
               plru_upd     = 1'b1;
               state_d      = IDLE;
               if (wr_q) arr_we = 1'b1;
               else bus.mem_rdata = hit_line;
            end else begin
               victim_d = victim;
               if (valid_q[victim][idx] && dirty_q[victim][idx])
                  state_d = WRITEBACK;
               else
                  state_d = FILL;
            end
         end
         WRITEBACK: begin
            bus.pmem_write   = 1'b1;
            bus.pmem_address = {tag_q[victim_q][idx], idx,
                                {s_offset{1'b0}}};
            bus.pmem_wdata   = data_q[victim_q][idx];
            if (bus.pmem_resp) state_d = FILL;
         end
         FILL: begin
            bus.pmem_read    = 1'b1;
            bus.pmem_address = {tag, idx, {s_offset{1'b0}}};
            if (bus.pmem_resp) begin
               arr_we    = 1'b1;
               arr_way   = victim_q;
               arr_line  = bus.pmem_rdata;
               arr_dirty = 1'b0;
               state_d   = CHECK;
            end
         end
      endcase
   end

   l2_plru #(
      .NUM_WAYS (NUM_WAYS),
      .SETS     (SETS)
   ) u_plru (
      .clk      (clk),
      .rst      (rst),
      .idx_i    (idx),
      .upd_i    (plru_upd),
      .way_i    (hit_way),
      .victim_o (plru_way)
   );

   // A reset edge suppresses the array write of an in-flight fill.
   always_ff @(posedge clk) begin
      if (rst && arr_we) begin
         data_q[arr_way][idx] <= arr_line;
         tag_q[arr_way][idx]  <= tag;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         wdata_q  <= '0;
         be_q     <= '0;
         wr_q     <= 1'b0;
         victim_q <= '0;
         valid_q  <= '{default: '0};
         dirty_q  <= '{default: '0};
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         be_q     <= be_d;
         wr_q     <= wr_d;
         victim_q <= victim_d;
         if (arr_we) begin
            valid_q[arr_way][idx] <= 1'b1;
            dirty_q[arr_way][idx] <= arr_dirty;
         end
      end
   end

`ifdef L2_PERF_CNT_EN
   logic [31:0] hit_cnt_q, hit_cnt_d;
   logic [31:0] miss_cnt_q, miss_cnt_d;

   always_comb begin
      hit_cnt_d  = hit_cnt_q;
      miss_cnt_d = miss_cnt_q;
      if (state_q == CHECK) begin
         if (hit) hit_cnt_d = hit_cnt_q + 32'd1;
         else miss_cnt_d = miss_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end

   assign hit_count  = hit_cnt_q;
   assign miss_count = miss_cnt_q;
`endif

endmodule

// File: doc/l2_cache_nway.md
L2_CACHE_NWAY -- requirements
Module: l2_cache_nway

Interface
REQ-001 SHALL provide parameter s_offset, default 5, line-offset bits (32-byte line).
REQ-002 SHALL provide parameter s_index, default 4, set-index bits (16 sets).
REQ-003 SHALL provide parameter NUM_WAYS, default 4, associativity; power of two, 2..8.
REQ-004 SHALL use one clock and a synchronous, active-low reset, with ports as follows:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-low reset
- mem_address  in  32  upstream line address
- mem_read  in  1  upstream read request
- mem_write  in  1  upstream write request
- mem_byte_enable  in  2**s_offset  per-byte write mask
- mem_wdata  in  8*2**s_offset  upstream write line
- mem_rdata  out  8*2**s_offset  upstream read line
- mem_resp  out  1  one-cycle completion pulse
- pmem_address  out  32  line-aligned memory address
- pmem_read  out  1  memory read request
- pmem_write  out  1  memory write request
- pmem_wdata  out  8*2**s_offset  writeback line
- pmem_rdata  in  8*2**s_offset  fill line
- pmem_resp  in  1  memory completion pulse

Function
REQ-005 SHALL be NUM_WAYS-way set-associative, write-back, write-allocate, with per-way valid, dirty and tag arrays and a per-set tree pseudo-LRU of NUM_WAYS-1 bits.
REQ-006 SHALL implement FSM states IDLE, CHECK, WRITEBACK, FILL.
REQ-007 SHALL, in IDLE with mem_read or mem_write high, register the address, data and byte enable and go to CHECK the next cycle.
REQ-008 SHALL, in CHECK on hit, pulse mem_resp for exactly one cycle (hit latency 2 cycles from request), update PLRU toward the hit way and return to IDLE.
REQ-009 SHALL, on a read hit, drive mem_rdata with the hit way's line in the mem_resp cycle.
REQ-010 SHALL, on a write hit, merge mem_wdata into the hit line byte-wise under mem_byte_enable and set that way's dirty bit.
REQ-011 SHALL, on miss, select the lowest-indexed invalid way as victim, else the PLRU way.
REQ-012 SHALL, on miss, go to WRITEBACK if the victim is valid and dirty, else to FILL.
REQ-013 SHALL, in WRITEBACK, hold pmem_write high with pmem_address = {victim tag, index, 0} and pmem_wdata = victim line until pmem_resp, then go to FILL.
REQ-014 SHALL, in FILL, hold pmem_read high with pmem_address = {tag, index, 0} until pmem_resp, then write the line, set valid, clear dirty and return to CHECK (guaranteed hit).
REQ-015 SHALL never assert pmem_read and pmem_write together.
REQ-016 SHALL treat mem_read and mem_write both high as a write.
REQ-017 SHALL ignore upstream request changes outside IDLE; requesters hold the request until mem_resp.
REQ-018 SHALL treat a pmem_resp outside WRITEBACK or FILL as a no-op.

Reset
REQ-019 SHALL, while rst is low at a clock edge, enter IDLE, clear all valid, dirty and PLRU bits, and drive mem_resp, pmem_read and pmem_write to 0; mem_rdata, pmem_address and pmem_wdata are 0.
REQ-020 SHALL, on reset during WRITEBACK or FILL, abandon the transaction without completing the array write.

Configuration
REQ-021 SHALL, with L2_PERF_CNT_EN defined, add outputs hit_count and miss_count, 32 bits each. These are cleared by reset, incremented once per CHECK hit and once per miss respectively, and wrap at 2**32.
REQ-022 SHALL, without L2_PERF_CNT_EN, omit those ports and counters entirely.

Structure
REQ-023 SHALL place the state enum, the PLRU width helper and the line-width constants in package l2_cache_pkg.
REQ-024 SHALL implement the pseudo-LRU (update on access, victim lookup) as sub-module l2_plru, instantiated once.

Verification
REQ-025 SHALL include: a read to 0x0000_1000 on a cold cache, which produces pmem_read with pmem_address 0x0000_1000, then mem_resp with the fill data; a repeat read returns mem_resp 2 cycles after the request with no pmem activity.
REQ-026 SHALL include: a write of 0xAA to byte 3 of 0x0000_1000 (mem_byte_enable 0x0000_0008), followed by a read, which returns the merged line with only byte 3 changed.
REQ-027 SHALL include: NUM_WAYS+1 distinct tags to set 0 with the first line dirty; the last miss issues pmem_write of the dirty line to its old address before pmem_read.
REQ-028 SHALL include: accesses to ways 0,1,2,3, then way 0 again, then a new tag; the victim is the PLRU way (way 2 for 4-way), with no eviction of way 0.
REQ-029 SHALL include: rst driven low during FILL with pmem_resp withheld; pmem_read drops next edge, and a subsequent read of the same address misses.
REQ-030 SHALL include: mem_read and mem_write both high; the line is updated as a write and exactly one mem_resp is produced.
